program_memory_arbiter: RTL and testbench

PROGRAM_MEMORY_ARBITER -- requirements
Module: program_memory_arbiter

---
 rtl/program_memory_arbiter_if.sv | 50 +++++
 rtl/program_memory_arbiter.sv | 112 +++++++++++
 tb/tb_program_memory_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/program_memory_arbiter_if.sv
// Bundle between the program memory arbiter, its two requesters (fetch, loader)
// and the single-port synchronous program memory.
interface program_memory_arbiter_if #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32
);
  localparam int unsigned AW = $clog2(MEMORY_DEPTH);

  logic                  fetch_req_i;
  logic [DATA_WIDTH-1:0] fetch_addr_i;
  logic                  fetch_gnt_o;
  logic                  fetch_valid_o;
  logic [DATA_WIDTH-1:0] fetch_rdata_o;
  logic                  fetch_err_o;

  logic                  load_req_i;
  logic                  load_we_i;
  logic [DATA_WIDTH-1:0] load_addr_i;
  logic [DATA_WIDTH-1:0] load_wdata_i;
  logic                  load_gnt_o;
  logic                  load_valid_o;
  logic [DATA_WIDTH-1:0] load_rdata_o;
  logic                  load_err_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [AW-1:0]         mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  // Arbiter side
  modport slave (
    input  fetch_req_i, fetch_addr_i,
    input  load_req_i, load_we_i, load_addr_i, load_wdata_i,
    input  mem_rdata_i,
    output fetch_gnt_o, fetch_valid_o, fetch_rdata_o, fetch_err_o,
    output load_gnt_o, load_valid_o, load_rdata_o, load_err_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Requester / memory side
  modport master (
    output fetch_req_i, fetch_addr_i,
    output load_req_i, load_we_i, load_addr_i, load_wdata_i,
    output mem_rdata_i,
    input  fetch_gnt_o, fetch_valid_o, fetch_rdata_o, fetch_err_o,
    input  load_gnt_o, load_valid_o, load_rdata_o, load_err_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/program_memory_arbiter.sv
// Two-requester (fetch / loader) arbiter for a single-port program memory.
// Each transaction runs IDLE -> ACCESS -> RESP with round-robin on contention.
module program_memory_arbiter #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input logic                     clk,
  input logic                     reset,
  program_memory_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(MEMORY_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic WIN_FETCH = 1'b0;
  localparam logic WIN_LOAD  = 1'b1;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  last_winner;
  logic                  grant_c;
  logic                  winner_c;
  logic                  win_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  txn_err_c;

  // Misaligned or beyond the last word
  assign txn_err_c = (addr_q[1:0] != 2'b00) ||
                     ((addr_q >> 2) >= DATA_WIDTH'(MEMORY_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Transaction capture on grant; last_winner resets to loader so fetch wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner <= WIN_LOAD;
      win_q       <= WIN_FETCH;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else if (grant_c) begin
      last_winner <= winner_c;
      win_q       <= winner_c;
      we_q        <= (winner_c == WIN_LOAD) && bus.load_we_i;
      addr_q      <= (winner_c == WIN_LOAD) ? bus.load_addr_i : bus.fetch_addr_i;
      wdata_q     <= (winner_c == WIN_LOAD) ? bus.load_wdata_i : '0;
    end
  end

  always_comb begin
    state_nxt         = state;
    grant_c           = 1'b0;
    winner_c          = WIN_FETCH;
    bus.fetch_gnt_o   = 1'b0;
    bus.fetch_valid_o = 1'b0;
    bus.fetch_rdata_o = '0;
    bus.fetch_err_o   = 1'b0;
    bus.load_gnt_o    = 1'b0;
    bus.load_valid_o  = 1'b0;
    bus.load_rdata_o  = '0;
    bus.load_err_o    = 1'b0;
    bus.mem_en_o      = 1'b0;
    bus.mem_we_o      = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_wdata_o   = '0;

    // Outputs are forced quiet for as long as reset is held
    if (!reset) begin
      case (state)
        IDLE: begin
          if (bus.fetch_req_i || bus.load_req_i) begin
            grant_c  = 1'b1;
            winner_c = (bus.fetch_req_i && bus.load_req_i) ? ~last_winner
                                                           : bus.load_req_i;
            if (winner_c == WIN_LOAD) bus.load_gnt_o  = 1'b1;
            else                      bus.fetch_gnt_o = 1'b1;
            state_nxt = ACCESS;
          end
        end
        ACCESS: begin
          if (!txn_err_c) begin
            bus.mem_en_o    = 1'b1;
            bus.mem_we_o    = we_q;
            bus.mem_addr_o  = addr_q[AW+1:2];
            bus.mem_wdata_o = wdata_q;
          end
          state_nxt = RESP;
        end
        RESP: begin
          if (win_q == WIN_LOAD) begin
            bus.load_valid_o = 1'b1;
            bus.load_err_o   = txn_err_c;
            bus.load_rdata_o = (!txn_err_c && !we_q) ? bus.mem_rdata_i : '0;
          end else begin
            bus.fetch_valid_o = 1'b1;
            bus.fetch_err_o   = txn_err_c;
            bus.fetch_rdata_o = !txn_err_c ? bus.mem_rdata_i : '0;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_memory_arbiter.sv
// Randomized bench for program_memory_arbiter against a transaction-level model
// (grant slot every 3 cycles, alternating priority, shadow memory contents).
module tb_program_memory_arbiter;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  program_memory_arbiter_if #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();
  program_memory_arbiter #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Synchronous single-port program memory
  logic [31:0] ram [DEPTH];
  logic [31:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              ram_q <= ram[bus.mem_addr_o];
    end
  end
  assign bus.mem_rdata_i = ram_q;

  // Stimulus
  bit          rst_v = 1'b1;
  bit          f_req, l_req, l_we, hold;
  logic [31:0] f_addr, l_addr, l_wd;

  // Reference model
  logic [31:0] ref_mem [DEPTH];
  int          cyc, free_at;
  bit          fetch_first;
  bit          t_act, t_load, t_we, t_err;
  int          t_start;
  logic [31:0] t_addr, t_wd;

  // Observations for directed checks
  logic [31:0] last_f_rdata, last_l_rdata;
  logic        last_f_err, last_l_err;
  int          vcount;
  bit          log_on;
  int          gnt_port [$];
  int          gnt_cyc  [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 7);
    case (k)
      5:       rand_addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      6:       rand_addr = 32'((DEPTH + $urandom_range(0, 7)) * 4);
      7:       rand_addr = $urandom;
      default: rand_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
    endcase
  endfunction

  task automatic cycle();
    logic        fg, lg, fv, lv, fe, le, me, mw;
    logic [31:0] fr, lr, ma, mwd;
    bit          pick_load;
    @(negedge clk);
    reset             = rst_v;
    bus.fetch_req_i   = f_req;
    bus.fetch_addr_i  = f_addr;
    bus.load_req_i    = l_req;
    bus.load_we_i     = l_we;
    bus.load_addr_i   = l_addr;
    bus.load_wdata_i  = l_wd;
    #1;
    {fg, lg, fv, lv, fe, le, me, mw} = '0;
    {fr, lr, ma, mwd} = '0;
    if (rst_v) begin
      t_act       = 1'b0;
      fetch_first = 1'b1;
      free_at     = cyc + 1;
    end else begin
      if (t_act && cyc == t_start + 1 && !t_err) begin
        me  = 1'b1;
        mw  = t_we;
        ma  = t_addr >> 2;
        mwd = t_wd;
      end
      if (t_act && cyc == t_start + 2) begin
        if (t_load) begin
          lv = 1'b1; le = t_err;
          lr = (!t_err && !t_we) ? ref_mem[t_addr >> 2] : 32'h0;
        end else begin
          fv = 1'b1; fe = t_err;
          fr = !t_err ? ref_mem[t_addr >> 2] : 32'h0;
        end
        t_act = 1'b0;
      end
      if (cyc >= free_at && (f_req || l_req)) begin
        pick_load   = l_req && !(f_req && fetch_first);
        fetch_first = pick_load;
        if (pick_load) lg = 1'b1; else fg = 1'b1;
        t_act   = 1'b1;
        t_start = cyc;
        t_load  = pick_load;
        t_addr  = pick_load ? l_addr : f_addr;
        t_we    = pick_load && l_we;
        t_wd    = pick_load ? l_wd : 32'h0;
        t_err   = (t_addr[1:0] != 2'b00) || ((t_addr >> 2) >= DEPTH);
        free_at = cyc + 3;
        if (t_we && !t_err) ref_mem[t_addr >> 2] = t_wd;
      end
    end

    check("ctl{fg,lg,fv,lv,fe,le,en,we}",
          32'({bus.fetch_gnt_o, bus.load_gnt_o, bus.fetch_valid_o, bus.load_valid_o,
               bus.fetch_err_o, bus.load_err_o, bus.mem_en_o, bus.mem_we_o}),
          32'({fg, lg, fv, lv, fe, le, me, mw}));
    check("fetch_rdata", bus.fetch_rdata_o, fr);
    check("load_rdata",  bus.load_rdata_o,  lr);
    check("mem_addr",    32'(bus.mem_addr_o), ma);
    check("mem_wdata",   bus.mem_wdata_o,   mwd);

    if (bus.fetch_valid_o) begin last_f_rdata = bus.fetch_rdata_o; last_f_err = bus.fetch_err_o; vcount++; end
    if (bus.load_valid_o)  begin last_l_rdata = bus.load_rdata_o;  last_l_err = bus.load_err_o;  vcount++; end
    if (log_on && bus.fetch_gnt_o) begin gnt_port.push_back(0); gnt_cyc.push_back(cyc); end
    if (log_on && bus.load_gnt_o)  begin gnt_port.push_back(1); gnt_cyc.push_back(cyc); end
    if (!hold) begin
      if (fg) f_req = 1'b0;
      if (lg) l_req = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    int exp_port [4];
    exp_port = '{0, 1, 0, 1};
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    f_req = 0; l_req = 0; l_we = 0; hold = 0; log_on = 0;
    f_addr = '0; l_addr = '0; l_wd = '0;
    cyc = 0; free_at = 0; fetch_first = 1; t_act = 0; vcount = 0;
    last_f_rdata = '0; last_l_rdata = '0; last_f_err = 0; last_l_err = 0;

    rst_v = 1; repeat (3) cycle();
    rst_v = 0;

    // Fetch-only read of word 2, granted in the first cycle after reset
    f_req = 1; f_addr = 32'h8; repeat (4) cycle();
    check("fetch_rom2", last_f_rdata, ref_mem[2]);

    // Contention from reset release: fetch, load, fetch, load, 3 cycles apart
    rst_v = 1; cycle(); rst_v = 0;
    f_req = 1; l_req = 1; l_we = 0; f_addr = 32'h0; l_addr = 32'h4;
    hold = 1; log_on = 1;
    repeat (12) cycle();
    hold = 0; log_on = 0; f_req = 0; l_req = 0;
    repeat (3) cycle();
    check("gnt_count", 32'(gnt_port.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_port.size()) begin
        check("gnt_order", 32'(gnt_port[i]), 32'(exp_port[i]));
        if (i > 0) check("gnt_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
      end
    end

    // Loader write then fetch of the same word
    l_req = 1; l_we = 1; l_addr = 32'h10; l_wd = 32'hDEADBEEF; repeat (3) cycle();
    check("load_wr_rdata", last_l_rdata, 32'h0);
    f_req = 1; f_addr = 32'h10; repeat (3) cycle();
    check("wr_then_fetch", last_f_rdata, 32'hDEADBEEF);

    // Error cases
    f_req = 1; f_addr = 32'h6; repeat (3) cycle();
    check("fetch_misaligned_err", 32'(last_f_err), 32'd1);
    l_req = 1; l_we = 0; l_addr = 32'h80; repeat (3) cycle();
    check("load_oob_err", 32'(last_l_err), 32'd1);
    l_req = 1; l_we = 0; l_addr = 32'h7C; repeat (3) cycle();
    check("load_last_word_err", 32'(last_l_err), 32'd0);
    check("load_last_word_data", last_l_rdata, ref_mem[31]);

    // Reset during ACCESS aborts the transaction
    vcount = 0;
    f_req = 1; f_addr = 32'hC; cycle();
    rst_v = 1; cycle(); rst_v = 0;
    repeat (3) cycle();
    check("abort_no_valid", 32'(vcount), 32'd0);
    f_req = 1; f_addr = 32'hC; repeat (3) cycle();
    check("post_reset_valid", 32'(vcount), 32'd1);

    // Randomized traffic with occasional resets
    repeat (800) begin
      if (!f_req && $urandom_range(0, 2) == 0) begin f_req = 1; f_addr = rand_addr(); end
      if (!l_req && $urandom_range(0, 2) == 0) begin
        l_req = 1; l_addr = rand_addr(); l_we = 1'($urandom_range(0, 1)); l_wd = $urandom;
      end
      rst_v = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst_v = 0; f_req = 0; l_req = 0;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
